// File: rtl/mlp_layer_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : mlp_layer_sequencer_if
// Description : Handshake, operand-fetch address and MAC-control bundle
//               between the MLP layer sequencer (master) and the
//               RAM / MAC / activation datapath (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mlp_layer_sequencer_if #(
    parameter int LAYER_W = 2,
    parameter int IDX_W   = 9,
    parameter int WADDR_W = 16
) ();

    // Run control
    logic                       start;
    logic                       stall;
    logic                       busy;
    logic                       done;

    // Operand fetch side (issue cycle)
    logic [LAYER_W-1:0]         layer_idx;
    logic [LAYER_W+IDX_W-1:0]   in_neuron_addr;
    logic [WADDR_W-1:0]         weight_addr;

    // MAC / write-back side (delayed by the fetch + multiply latency)
    logic                       mac_en;
    logic                       mac_clear;
    logic                       write_neuron;
    logic [LAYER_W+IDX_W-1:0]   out_neuron_addr;
    logic                       relu_en;

    // Sequencer side
    modport master (
        input  start,
        input  stall,
        output busy,
        output done,
        output layer_idx,
        output in_neuron_addr,
        output weight_addr,
        output mac_en,
        output mac_clear,
        output write_neuron,
        output out_neuron_addr,
        output relu_en
    );

    // Datapath / controller side
    modport slave (
        output start,
        output stall,
        input  busy,
        input  done,
        input  layer_idx,
        input  in_neuron_addr,
        input  weight_addr,
        input  mac_en,
        input  mac_clear,
        input  write_neuron,
        input  out_neuron_addr,
        input  relu_en
    );

endinterface
`default_nettype wire

// File: rtl/mlp_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mlp_layer_sequencer
// Description : Parametrised address/control sequencer for a layer-serial
//               MLP datapath. Walks layers, output neurons and input weights,
//               issuing one MAC operand fetch per cycle, and produces
//               latency-matched MAC/write-back controls.
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_layer_sequencer #(
    parameter int                       NUM_LAYERS  = 4,
    parameter logic [16*NUM_LAYERS-1:0] LAYER_SIZES = {16'd10, 16'd16, 16'd30, 16'd432},
    parameter int                       IDX_W       = 9,
    parameter int                       LAYER_W     = 2,
    parameter int                       WADDR_W     = 16,
    parameter int                       PIPE_LAT    = 2
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    mlp_layer_sequencer_if.master   ctrl
);

    // ------------------------------------------------------------------------
    // Elaboration-time configuration checks
    // ------------------------------------------------------------------------
    function automatic longint total_weights();
        longint t;
        t = 0;
        for (int i = 0; i < NUM_LAYERS - 1; i++) begin
            t += longint'(LAYER_SIZES[i*16 +: 16]) * longint'(LAYER_SIZES[(i+1)*16 +: 16]);
        end
        return t;
    endfunction

    localparam longint TOTAL_WEIGHTS = total_weights();
    localparam int     NSLOT         = 2 ** LAYER_W;
    localparam int     DRAIN_W       = $clog2(PIPE_LAT + 2);
    localparam int     ADDR_W        = LAYER_W + IDX_W;

    generate
        if (NUM_LAYERS < 2 || PIPE_LAT < 1 || NSLOT < NUM_LAYERS || IDX_W > 16 ||
            TOTAL_WEIGHTS > (longint'(1) << WADDR_W)) begin : g_bad_cfg
            $fatal(1, "mlp_layer_sequencer: illegal parameter combination");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Layer size lookup, indexed by layer number (unused slots read as 0)
    // ------------------------------------------------------------------------
    logic [IDX_W-1:0] size_tbl [NSLOT];

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_size
            if (gi < NUM_LAYERS) begin : g_used
                assign size_tbl[gi] = LAYER_SIZES[gi*16 +: IDX_W];
            end else begin : g_unused
                assign size_tbl[gi] = '0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State, counters and issue-tag pipeline
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // One entry per cycle travelling alongside the RAM read + multiply.
    typedef struct packed {
        logic              valid;
        logic              first;
        logic              last;
        logic              relu;
        logic [ADDR_W-1:0] dst;
    } tag_t;

    state_t               state_q,  state_d;
    logic [LAYER_W-1:0]   layer_q,  layer_d;
    logic [IDX_W-1:0]     neuron_q, neuron_d;
    logic [IDX_W-1:0]     wgt_q,    wgt_d;
    logic [WADDR_W-1:0]   waddr_q,  waddr_d;
    logic [DRAIN_W-1:0]   drain_q,  drain_d;
    tag_t                 pipe_q [PIPE_LAT];
    tag_t                 tag_d;

    logic [LAYER_W-1:0]   layer_nxt;
    logic                 last_w;
    logic                 last_n;
    logic                 final_layer;
    logic                 issue;

    assign layer_nxt   = layer_q + LAYER_W'(1);
    assign last_w      = (wgt_q == size_tbl[layer_q] - IDX_W'(1));
    assign last_n      = (neuron_q == size_tbl[layer_nxt] - IDX_W'(1));
    assign final_layer = (layer_nxt == LAYER_W'(NUM_LAYERS - 1));

    // State and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            layer_q  <= '0;
            neuron_q <= '0;
            wgt_q    <= '0;
            waddr_q  <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            neuron_q <= neuron_d;
            wgt_q    <= wgt_d;
            waddr_q  <= waddr_d;
            drain_q  <= drain_d;
        end
    end

    // Next-state logic: walk weight -> neuron -> layer, barrier between layers.
    // On the final issue of a layer the weight/neuron counters are left alone
    // so the fetch address holds the last issued value through the drain.
    always_comb begin
        state_d  = state_q;
        layer_d  = layer_q;
        neuron_d = neuron_q;
        wgt_d    = wgt_q;
        waddr_d  = waddr_q;
        drain_d  = drain_q;
        issue    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (ctrl.start) begin
                    state_d  = S_RUN;
                    layer_d  = '0;
                    neuron_d = '0;
                    wgt_d    = '0;
                    waddr_d  = '0;
                end
            end

            S_RUN: begin
                if (!ctrl.stall) begin
                    issue   = 1'b1;
                    waddr_d = waddr_q + WADDR_W'(1);
                    if (last_w) begin
                        if (last_n) begin
                            state_d = S_DRAIN;
                            drain_d = '0;
                        end else begin
                            wgt_d    = '0;
                            neuron_d = neuron_q + IDX_W'(1);
                        end
                    end else begin
                        wgt_d = wgt_q + IDX_W'(1);
                    end
                end
            end

            S_DRAIN: begin
                // PIPE_LAT+1 cycles so the layer's last write lands before
                // the next layer starts reading those neurons.
                if (drain_q == DRAIN_W'(PIPE_LAT)) begin
                    if (final_layer) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_RUN;
                        layer_d  = layer_nxt;
                        neuron_d = '0;
                        wgt_d    = '0;
                    end
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Tag for this cycle: a real operand on issue, otherwise an all-zero bubble
    always_comb begin
        tag_d = '0;
        if (issue) begin
            tag_d.valid = 1'b1;
            tag_d.first = (wgt_q == '0);
            tag_d.last  = last_w;
            tag_d.relu  = !final_layer;
            tag_d.dst   = {layer_nxt, neuron_q};
        end
    end

    // Latency-matching shift register; advances every cycle, stalled or not
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_d;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: all derived from registers so reset clears them immediately
    // ------------------------------------------------------------------------
    assign ctrl.busy            = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign ctrl.done            = (state_q == S_DONE);
    assign ctrl.layer_idx       = layer_q;
    assign ctrl.in_neuron_addr  = {layer_q, wgt_q};
    assign ctrl.weight_addr     = waddr_q;
    assign ctrl.mac_en          = pipe_q[PIPE_LAT-1].valid;
    assign ctrl.mac_clear       = pipe_q[PIPE_LAT-1].valid & pipe_q[PIPE_LAT-1].first;
    assign ctrl.write_neuron    = pipe_q[PIPE_LAT-1].valid & pipe_q[PIPE_LAT-1].last;
    assign ctrl.out_neuron_addr = pipe_q[PIPE_LAT-1].dst;
    assign ctrl.relu_en         = pipe_q[PIPE_LAT-1].relu;

endmodule
`default_nettype wire

// File: tb/tb_mlp_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mlp_layer_sequencer
// Description : Self-checking bench for mlp_layer_sequencer. A small
//               3-layer instance is checked cycle by cycle against a
//               behavioural model; a default-size instance checks totals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mlp_layer_sequencer;

    localparam int          P  = 2;
    localparam int          NL = 3;
    localparam logic [47:0] SZ = {16'd2, 16'd3, 16'd4};
    localparam int          HIST = 8192;

    logic clk;
    logic reset_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mlp_layer_sequencer_if #(.LAYER_W(2), .IDX_W(9), .WADDR_W(16)) sif ();
    mlp_layer_sequencer_if #(.LAYER_W(2), .IDX_W(9), .WADDR_W(16)) bif ();

    mlp_layer_sequencer #(
        .NUM_LAYERS (NL),
        .LAYER_SIZES(SZ),
        .IDX_W      (9),
        .LAYER_W    (2),
        .WADDR_W    (16),
        .PIPE_LAT   (P)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .ctrl   (sif.master)
    );

    mlp_layer_sequencer big (
        .clk    (clk),
        .reset_n(reset_n),
        .ctrl   (bif.master)
    );

    // ------------------------------------------------------------------------
    // Reference model data
    // ------------------------------------------------------------------------
    typedef struct {
        int l;
        int n;
        int w;
        int wa;
        bit first;
        bit last;
        bit lay_end;
    } iss_t;

    iss_t iss_list[$];
    int   issue_at [HIST];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   phase = 0;      // 0 idle, 1 run, 2 drain, 3 done
    int   k     = 0;
    int   dcnt  = 0;
    int   run_start = 0;
    int   obs_w[$];
    int   done_rel = -1;

    function automatic int sz(input int i);
        logic [47:0] v;
        v = SZ;
        return int'(v[i*16 +: 16]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_busy"},  32'(sif.busy), 0);
        check({pfx, "_done"},  32'(sif.done), 0);
        check({pfx, "_layer"}, 32'(sif.layer_idx), 0);
        check({pfx, "_inadr"}, 32'(sif.in_neuron_addr), 0);
        check({pfx, "_wadr"},  32'(sif.weight_addr), 0);
        check({pfx, "_mac"},   32'(sif.mac_en), 0);
        check({pfx, "_clr"},   32'(sif.mac_clear), 0);
        check({pfx, "_wr"},    32'(sif.write_neuron), 0);
        check({pfx, "_oadr"},  32'(sif.out_neuron_addr), 0);
        check({pfx, "_relu"},  32'(sif.relu_en), 0);
    endtask

    // One clock cycle on the small instance: drive, sample mid-cycle,
    // compare with the model, then advance the model.
    task automatic cycle(input bit st, input bit sl);
        int j;
        @(posedge clk);
        #1;
        sif.start = st;
        sif.stall = sl;
        @(negedge clk);
        issue_at[cyc % HIST] = -1;
        check("busy", 32'(sif.busy), 32'(phase == 1 || phase == 2));
        check("done", 32'(sif.done), 32'(phase == 3));
        if (phase == 1 && !sl) begin
            check("weight_addr", 32'(sif.weight_addr), iss_list[k].wa);
            check("in_addr", 32'(sif.in_neuron_addr), (iss_list[k].l << 9) | iss_list[k].w);
            check("layer_idx", 32'(sif.layer_idx), iss_list[k].l);
            issue_at[cyc % HIST] = k;
        end
        j = (cyc >= P) ? issue_at[(cyc - P) % HIST] : -1;
        check("mac_en", 32'(sif.mac_en), 32'(j >= 0));
        check("mac_clear", 32'(sif.mac_clear), 32'(j >= 0 && iss_list[j].first));
        check("write", 32'(sif.write_neuron), 32'(j >= 0 && iss_list[j].last));
        if (j >= 0 && iss_list[j].last) begin
            check("out_addr", 32'(sif.out_neuron_addr), ((iss_list[j].l + 1) << 9) | iss_list[j].n);
            check("relu_en", 32'(sif.relu_en), 32'(iss_list[j].l + 1 != NL - 1));
        end
        if (sif.write_neuron === 1'b1) obs_w.push_back(cyc - run_start);
        if (sif.done === 1'b1 && done_rel < 0) done_rel = cyc - run_start;
        case (phase)
            0, 3: if (st) begin
                phase = 1;
                k = 0;
                run_start = cyc;
                obs_w.delete();
                done_rel = -1;
            end
            1: if (!sl) begin
                if (iss_list[k].lay_end) begin
                    phase = 2;
                    dcnt  = 0;
                end
                k++;
            end
            2: begin
                dcnt++;
                if (dcnt == P + 1) phase = (iss_list[k-1].l == NL - 2) ? 3 : 1;
            end
            default: phase = 0;
        endcase
        cyc++;
    endtask

    task automatic check_writes(input string tag, input int exp[$], input int exp_done);
        check({tag, "_nwr"}, obs_w.size(), exp.size());
        for (int i = 0; i < exp.size() && i < obs_w.size(); i++) begin
            check({tag, "_wrcyc"}, obs_w[i], exp[i]);
        end
        check({tag, "_donecyc"}, done_rel, exp_done);
    endtask

    task automatic run_to_done(input string tag, input int stall_pct, input int start_pct);
        int n;
        n = 0;
        while (phase != 3 && n < 300) begin
            cycle(($urandom % 100) < start_pct, ($urandom % 100) < stall_pct);
            n++;
        end
        check({tag, "_reached_done"}, 32'(phase == 3), 1);
    endtask

    // ------------------------------------------------------------------------
    // Directed + random sequence
    // ------------------------------------------------------------------------
    initial begin
        int wa;
        int bc;
        int big_wa;
        int big_wr;
        int big_done;

        reset_n   = 1'b0;
        sif.start = 1'b0;
        sif.stall = 1'b0;
        bif.start = 1'b0;
        bif.stall = 1'b0;
        for (int i = 0; i < HIST; i++) issue_at[i] = -1;

        wa = 0;
        for (int l = 0; l < NL - 1; l++)
            for (int n = 0; n < sz(l + 1); n++)
                for (int w = 0; w < sz(l); w++) begin
                    iss_list.push_back('{l: l, n: n, w: w, wa: wa, first: (w == 0),
                                         last: (w == sz(l) - 1),
                                         lay_end: (w == sz(l) - 1 && n == sz(l + 1) - 1)});
                    wa++;
                end

        // Reset values
        @(posedge clk);
        #1;
        check_zero("reset");
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        cycle(0, 0);

        // Unstalled run: timing from the start edge
        cycle(1, 0);
        repeat (30) cycle(0, 0);
        check_writes("nostall", '{6, 10, 14, 20, 23}, 25);

        // Restart from DONE, stall at 3-4, start pulsed mid-run (ignored)
        cycle(1, 0);
        cycle(0, 0);
        cycle(0, 0);
        cycle(0, 1);
        cycle(0, 1);
        repeat (5) cycle(0, 0);
        cycle(1, 0);
        repeat (25) cycle(0, 0);
        check_writes("stall", '{8, 12, 16, 22, 25}, 27);

        // Random stall / start traffic
        for (int r = 0; r < 6; r++) begin
            cycle(1, ($urandom % 3) == 0);
            run_to_done("rand", 30, 15);
            check("rand_nwr", obs_w.size(), 5);
            repeat ($urandom_range(0, 3)) cycle(0, 0);
        end

        // Asynchronous reset in the middle of a run
        cycle(1, 0);
        repeat (8) cycle(0, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("midreset");
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        cyc += 2;
        phase = 0;
        for (int i = 0; i < HIST; i++) issue_at[i] = -1;
        obs_w.delete();
        repeat (6) cycle(0, 0);
        check("post_reset_writes", obs_w.size(), 0);
        cycle(1, 0);
        repeat (30) cycle(0, 0);
        check_writes("fresh", '{6, 10, 14, 20, 23}, 25);

        // Default-size instance: totals
        big_wa   = -1;
        big_wr   = 0;
        big_done = -1;
        bc       = 0;
        @(posedge clk);
        #1;
        bif.start = 1'b1;
        while (big_done < 0 && bc < 14000) begin
            @(negedge clk);
            if (bc == 13606) big_wa = int'(bif.weight_addr);
            if (bif.write_neuron === 1'b1) big_wr++;
            if (bif.done === 1'b1) big_done = bc;
            @(posedge clk);
            #1;
            bif.start = 1'b0;
            bc++;
        end
        check("big_last_waddr", big_wa, 13599);
        check("big_writes", big_wr, 56);
        check("big_done_cycle", big_done, 13610);
        check("big_done_level", 32'(bif.done), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
